gray_code_generator: RTL and testbench

Streaming source of WIDTH-bit Gray codes that drives the G input of the downstream gray_to_binary decoder. An internal binary counter steps up or down by one per accepted transfer; the registered output is its Gray encoding. Output uses a valid/ready handshake so the consumer can stall. The block supports start/stop control, a preload of the start value, and an optional one-shot mode that stops after one full cycle of codes.

---
 rtl/gray_code_generator.sv | 91 +++++++++
 tb/tb_gray_code_generator.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_code_generator.sv
// Streaming Gray-code source with valid/ready output, preload, start/stop
// and optional one-shot wrap termination.
module gray_code_generator #(
    parameter int WIDTH    = 4,
    parameter bit ONE_SHOT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] G,
    output logic             g_valid,
    input  logic             g_ready,
    output logic             busy,
    output logic             wrap
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAXV = '1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] bin_nxt;
    logic             xfer;
    logic             wrap_nxt;

    assign xfer     = (state == RUN) && g_ready;
    assign wrap_nxt = xfer && (up_dn ? (bin == MAXV) : (bin == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // stop dominates start; one-shot treats the wrapping transfer as a stop
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop || (ONE_SHOT && wrap_nxt)) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        bin_nxt = bin;
        if ((state == IDLE) && load) begin
            bin_nxt = load_val;
        end else if (xfer) begin
            bin_nxt = up_dn ? (bin + ONE) : (bin - ONE);
        end
    end

    // G is loaded on the same edge as bin so it always equals gray(bin)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin  <= '0;
            G    <= '0;
            wrap <= 1'b0;
        end else begin
            bin  <= bin_nxt;
            G    <= bin_nxt ^ (bin_nxt >> 1);
            wrap <= wrap_nxt;
        end
    end

    always_comb begin
        g_valid = (state == RUN);
        busy    = (state == RUN);
    end

endmodule

// File: tb/tb_gray_code_generator.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against an arithmetic model, for free-running and one-shot instances.
module tb_gray_code_generator;

    localparam int W = 4;
    localparam int N = 16;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         start    = 1'b0;
    logic         stop     = 1'b0;
    logic         up_dn    = 1'b1;
    logic         load     = 1'b0;
    logic         g_ready  = 1'b0;
    logic [W-1:0] load_val = '0;

    logic [W-1:0] g0, g1;
    logic         v0, v1, b0, b1, w0, w1;

    int errs   = 0;
    int checks = 0;

    int mbin[2];
    bit mrun[2];
    bit mwrap[2];

    int seq1[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    int seq3[6]  = '{6, 2, 3, 1, 0, 8};

    always #5 clk = ~clk;

    gray_code_generator #(.WIDTH(W), .ONE_SHOT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .up_dn(up_dn), .load(load), .load_val(load_val),
        .G(g0), .g_valid(v0), .g_ready(g_ready),
        .busy(b0), .wrap(w0)
    );

    gray_code_generator #(.WIDTH(W), .ONE_SHOT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .up_dn(up_dn), .load(load), .load_val(load_val),
        .G(g1), .g_valid(v1), .g_ready(g_ready),
        .busy(b1), .wrap(w1)
    );

    function automatic int gray(int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            mbin[k]  = 0;
            mrun[k]  = 1'b0;
            mwrap[k] = 1'b0;
        end
    endtask

    task automatic mstep();
        for (int k = 0; k < 2; k++) begin
            bit xf;
            bit wr;
            xf = mrun[k] && g_ready;
            wr = xf && (up_dn ? (mbin[k] == N - 1) : (mbin[k] == 0));
            if (!mrun[k]) begin
                if (load) mbin[k] = int'(load_val);
                if (start && !stop) mrun[k] = 1'b1;
            end else begin
                if (xf) mbin[k] = (mbin[k] + (up_dn ? 1 : N - 1)) % N;
                if (stop || (k == 1 && wr)) mrun[k] = 1'b0;
            end
            mwrap[k] = wr;
        end
    endtask

    task automatic mcheck();
        chk("G0", 32'(g0), 32'(gray(mbin[0])));
        chk("valid0", 32'(v0), 32'(mrun[0]));
        chk("busy0", 32'(b0), 32'(mrun[0]));
        chk("wrap0", 32'(w0), 32'(mwrap[0]));
        chk("G1", 32'(g1), 32'(gray(mbin[1])));
        chk("valid1", 32'(v1), 32'(mrun[1]));
        chk("busy1", 32'(b1), 32'(mrun[1]));
        chk("wrap1", 32'(w1), 32'(mwrap[1]));
    endtask

    task automatic cyc();
        @(posedge clk);
        mstep();
        #1;
        mcheck();
    endtask

    // called 1 time unit after an edge; reset is applied between edges
    task automatic do_reset();
        rst = 1'b1;
        mreset();
        #2;
        mcheck();
        rst = 1'b0;
    endtask

    initial begin
        mreset();
        #2;
        mcheck();
        rst = 1'b0;

        // full up cycle; one-shot instance drops out after the wrap
        @(posedge clk);
        #1;
        do_reset();
        start   = 1'b1;
        up_dn   = 1'b1;
        g_ready = 1'b1;
        cyc();
        start = 1'b0;
        chk("t1_first", 32'(g0), 32'(seq1[0]));
        for (int i = 1; i < 17; i++) begin
            cyc();
            chk("t1_seq", 32'(g0), 32'(seq1[i]));
            chk("t1_wrap", 32'(w0), 32'(i == 16));
            chk("t1_busy", 32'(b0), 32'd1);
        end
        chk("t5_oneshot_valid", 32'(v1), 32'd0);
        chk("t5_oneshot_busy", 32'(b1), 32'd0);

        // stall at G=3
        do_reset();
        start   = 1'b1;
        g_ready = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        chk("t2_pre", 32'(g0), 32'd3);
        g_ready = 1'b0;
        repeat (5) begin
            up_dn = 1'($urandom);
            cyc();
            chk("t2_hold", 32'(g0), 32'd3);
            chk("t2_valid", 32'(v0), 32'd1);
        end
        g_ready = 1'b1;
        up_dn   = 1'b1;
        cyc();
        chk("t2_release", 32'(g0), 32'd2);

        // preload 5 then count down through the wrap
        do_reset();
        load     = 1'b1;
        load_val = 4'd5;
        cyc();
        load = 1'b0;
        chk("t3_loaded", 32'(g0), 32'd7);
        chk("t3_idle", 32'(v0), 32'd0);
        start = 1'b1;
        up_dn = 1'b0;
        cyc();
        start = 1'b0;
        chk("t3_first", 32'(g0), 32'd7);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t3_seq", 32'(g0), 32'(seq3[i]));
        end
        chk("t3_wrap", 32'(w0), 32'd1);

        // load and start on the same edge
        do_reset();
        load     = 1'b1;
        load_val = 4'd9;
        start    = 1'b1;
        cyc();
        load  = 1'b0;
        start = 1'b0;
        chk("ls_G", 32'(g0), 32'd13);
        chk("ls_valid", 32'(v0), 32'd1);

        // stop coinciding with a transfer at G=6, then resume
        do_reset();
        start   = 1'b1;
        up_dn   = 1'b1;
        g_ready = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        chk("t4_pre", 32'(g0), 32'd6);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("t4_valid", 32'(v0), 32'd0);
        chk("t4_busy", 32'(b0), 32'd0);
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t4_resume", 32'(g0), 32'd7);
        chk("t4_rvalid", 32'(v0), 32'd1);

        // start and stop together in IDLE
        do_reset();
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        chk("t5_ss0", 32'(v0), 32'd0);
        chk("t5_ss1", 32'(v1), 32'd0);

        // asynchronous reset mid-run
        do_reset();
        start   = 1'b1;
        g_ready = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        chk("t6_pre", 32'(g0), 32'd3);
        do_reset();
        chk("t6_G", 32'(g0), 32'd0);
        chk("t6_valid", 32'(v0), 32'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t6_restart", 32'(g0), 32'd0);

        // randomized traffic
        repeat (500) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end
            start    = ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 15) == 0);
            up_dn    = ($urandom_range(0, 3) != 0);
            load     = ($urandom_range(0, 3) == 0);
            load_val = W'($urandom);
            g_ready  = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
